writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
- Sits directly downstream of the execution units, including the custom unit. Consumes each unit's writeback handshake (done/id/rd, returning ack) and selects one result per cycle.
- Presents the selected result as a single registered writeback packet (valid/id/data) to the register-file write and ID-retire logic.
- Arbitration is round-robin for fairness, so a throughput-1 unit cannot starve multi-cycle units.
- Accepts backpressure from the downstream consumer.

Parameters:
- NUM_UNITS, 4, number of writeback sources (legal range 1..8).
- ID_W, 3, width of instruction ID.
- DATA_W, 32, width of result data.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- unit_done  input  NUM_UNITS  per-unit result valid; held until acked
- unit_id  input  NUM_UNITS x ID_W  per-unit instruction ID
- unit_rd  input  NUM_UNITS x DATA_W  per-unit result data
- unit_ack  output  NUM_UNITS  one-hot (or zero) accept; combinational
- wb_ready  input  1  downstream can take the packet this cycle
- wb_valid  output  1  registered packet valid
- wb_id  output  ID_W  registered packet ID
- wb_data  output  DATA_W  registered packet data

Behaviour:
- Reset (rst=1 at posedge clk): wb_valid=0, wb_id=0, wb_data=0, rr_ptr=0.
  - unit_ack is 0 combinationally while rst=1.
  - Reset mid-operation drops any held packet. Units keep done asserted, because unit_done is not acked, and are re-arbitrated after reset.
- Slot free: slot_free = ~wb_valid | wb_ready. The output register accepts a new packet only when slot_free=1.
- Grant (combinational):
  - If slot_free=0, unit_ack=0.
  - Otherwise, grant the first set unit_done bit found scanning from index rr_ptr upward, wrapping modulo NUM_UNITS.
  - Exactly one unit_ack bit is set if any done is set, else none.
  - unit_ack never asserts for a unit whose done=0.
- Output register, on posedge clk:
  - If a grant occurred: wb_valid<=1, wb_id<=unit_id[g], wb_data<=unit_rd[g].
  - Else if wb_ready: wb_valid<=0, and wb_id/wb_data hold their values.
  - Else: hold everything.
- Latency: unit result to wb_valid is 1 cycle.
- Throughput: 1 packet per cycle when wb_ready is held high.
- Pointer: on a grant to g, rr_ptr <= (g+1) mod NUM_UNITS, wrapping from NUM_UNITS-1 to 0. No grant means the pointer holds.
- Simultaneous accept-and-drain: wb_valid=1, wb_ready=1 and a new grant in the same cycle replaces the packet with no bubble.
- Backpressure: with wb_valid=1 and wb_ready=0, wb_id/wb_data stay stable and no ack is issued, so units remain done.
- NUM_UNITS=1: the pointer is constant 0 and the grant is done & slot_free.
- Protocol: a unit that sees its ack drops done next cycle unless it has a new result. The arbiter does not check this.

Optional Feature:
- Macro: CVA5_WB_UNIT0_PRIORITY_EN.
- Defined:
  - Unit 0 (ALU) has fixed highest priority. If unit_done[0]=1 and slot_free=1, unit 0 is granted regardless of rr_ptr.
  - The remaining units round-robin among indices 1..NUM_UNITS-1.
  - rr_ptr is updated only on grants to non-zero units, and ranges over 1..NUM_UNITS-1.
  - Reset value of rr_ptr is 1.
- Undefined: pure round-robin over all units, as above.

Decomposition:
- Shared package cva5_types:
  - wb_packet_t {id_t id; logic [31:0] data;}.
  - Constant WB_MAX_UNITS=8 for range checking.
- Sub-module rr_arbiter (parameter N):
  - Inputs: request vector, enable, pointer.
  - Output: one-hot grant.
  - Purely combinational, reused by the issue logic.
- The top module owns rr_ptr, the output register and the macro selection.

Test Plan:
- Single source: unit_done=4'b0100, id=5, rd=0x0000_00AA, wb_ready=1 -> unit_ack=4'b0100 the same cycle; next cycle wb_valid=1, wb_id=5, wb_data=0xAA; rr_ptr=3.
- Fairness: unit_done=4'b1111 held, each unit reasserting after ack, rr_ptr=0, wb_ready=1 -> grant order 0,1,2,3,0; one wb_valid packet per cycle with no bubbles.
- Backpressure: packet held with wb_ready=0 for 3 cycles while unit_done=4'b0010 -> unit_ack=0 for all 3 cycles, wb_id/wb_data stable. On the cycle wb_ready=1, unit_ack=4'b0010, and the new packet appears the next cycle.
- Wrap-around: rr_ptr=3, unit_done=4'b0011 -> grant unit 0; rr_ptr becomes 1.
- Reset mid-operation: wb_valid=1, rst pulsed 1 cycle -> wb_valid=0, rr_ptr=0. The undrained unit with done=1 is granted the first cycle after reset.
- With CVA5_WB_UNIT0_PRIORITY_EN: unit_done=4'b1001, rr_ptr=3 -> unit 0 granted, rr_ptr stays 3; next cycle, with only unit 3 done, unit 3 is granted.

Source files
------------

// File: rtl/writeback_arbiter_pkg.sv
// Shared writeback types and small helpers for the execution-unit writeback path.
// Imported by rr_arbiter consumers and by writeback_arbiter.
package cva5_types;

  localparam int WB_MAX_UNITS = 8;
  localparam int ID_W_DEF     = 3;

  typedef logic [ID_W_DEF-1:0] id_t;

  typedef struct packed {
    id_t         id;
    logic [31:0] data;
  } wb_packet_t;

  // Pointer width for an N-entry round-robin; a single entry still needs one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index after idx, wrapping back to lo once the top of the n-entry range is passed.
  function automatic int rr_next(input int idx, input int n, input int lo);
    return (idx + 1 >= n) ? lo : idx + 1;
  endfunction

endpackage

// File: rtl/writeback_arbiter_rr.sv
// Combinational round-robin arbiter: one-hot grant of the first request at or above
// the pointer, wrapping to the lowest request. Shared with the issue logic.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic             en_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

  logic [N-1:0] mask;
  logic [N-1:0] req_hi;
  logic [N-1:0] pick;

  // Prefer requests at or above the pointer; fall back to the full vector for the wrap.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(ptr_i));
    end
    req_hi = req_i & mask;
    pick   = (|req_hi) ? req_hi : req_i;
    gnt_o  = en_i ? (pick & (~pick + N'(1))) : '0;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: picks one execution-unit result per cycle into a registered packet.
// Build option CVA5_WB_UNIT0_PRIORITY_EN gives unit 0 fixed priority over the rest.
module writeback_arbiter
  import cva5_types::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int ID_W      = 3,
  parameter int DATA_W    = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_UNITS-1:0]             unit_done,
  input  logic [NUM_UNITS-1:0][ID_W-1:0]   unit_id,
  input  logic [NUM_UNITS-1:0][DATA_W-1:0] unit_rd,
  output logic [NUM_UNITS-1:0]             unit_ack,
  input  logic                             wb_ready,
  output logic                             wb_valid,
  output logic [ID_W-1:0]                  wb_id,
  output logic [DATA_W-1:0]                wb_data
);

  localparam int PTR_W = ptr_width(NUM_UNITS);
`ifdef CVA5_WB_UNIT0_PRIORITY_EN
  localparam int PTR_LO = (NUM_UNITS > 1) ? 1 : 0;
`else
  localparam int PTR_LO = 0;
`endif
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(PTR_LO);

  generate
    if (NUM_UNITS < 1 || NUM_UNITS > WB_MAX_UNITS) begin : g_bad_cfg
      $error("writeback_arbiter: NUM_UNITS out of range 1..%0d", WB_MAX_UNITS);
    end
  endgenerate

  logic                 wb_valid_q, wb_valid_d;
  logic [ID_W-1:0]      wb_id_q,    wb_id_d;
  logic [DATA_W-1:0]    wb_data_q,  wb_data_d;
  logic [PTR_W-1:0]     rr_ptr_q,   rr_ptr_d;

  logic                 slot_free;
  logic                 rr_en;
  logic [NUM_UNITS-1:0] rr_req;
  logic [NUM_UNITS-1:0] rr_gnt;
  logic                 granted;
  logic [ID_W-1:0]      sel_id;
  logic [DATA_W-1:0]    sel_data;

  // Reset also gates the grant so no unit believes it was accepted during reset.
  assign slot_free = (~wb_valid_q | wb_ready) & ~rst;

`ifdef CVA5_WB_UNIT0_PRIORITY_EN
  assign rr_req   = unit_done & ~NUM_UNITS'(1);
  assign rr_en    = slot_free & ~unit_done[0];
  assign unit_ack = rr_gnt | NUM_UNITS'(unit_done[0] & slot_free);
`else
  assign rr_req   = unit_done;
  assign rr_en    = slot_free;
  assign unit_ack = rr_gnt;
`endif

  rr_arbiter #(
    .N     (NUM_UNITS),
    .PTR_W (PTR_W)
  ) u_rr (
    .req_i (rr_req),
    .en_i  (rr_en),
    .ptr_i (rr_ptr_q),
    .gnt_o (rr_gnt)
  );

  // Grant is one-hot, so OR-ing the selected lanes forms the mux.
  always_comb begin
    granted  = |unit_ack;
    sel_id   = '0;
    sel_data = '0;
    rr_ptr_d = rr_ptr_q;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (unit_ack[i]) begin
        sel_id   = sel_id | unit_id[i];
        sel_data = sel_data | unit_rd[i];
`ifdef CVA5_WB_UNIT0_PRIORITY_EN
        if (i != 0) begin
          rr_ptr_d = PTR_W'(rr_next(i, NUM_UNITS, PTR_LO));
        end
`else
        rr_ptr_d = PTR_W'(rr_next(i, NUM_UNITS, PTR_LO));
`endif
      end
    end
  end

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_id_d    = wb_id_q;
    wb_data_d  = wb_data_q;
    if (granted) begin
      wb_valid_d = 1'b1;
      wb_id_d    = sel_id;
      wb_data_d  = sel_data;
    end else if (wb_ready) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_id_q    <= '0;
      wb_data_q  <= '0;
      rr_ptr_q   <= PTR_RST;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_id_q    <= wb_id_d;
      wb_data_q  <= wb_data_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_id    = wb_id_q;
  assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter; follows CVA5_WB_UNIT0_PRIORITY_EN when defined.
module tb_writeback_arbiter;

  localparam int N      = 4;
  localparam int ID_W   = 3;
  localparam int DATA_W = 32;
`ifdef CVA5_WB_UNIT0_PRIORITY_EN
  localparam int PTR_RST = 1;
`else
  localparam int PTR_RST = 0;
`endif

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } pkt_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [N-1:0]             unit_done;
  logic [N-1:0][ID_W-1:0]   unit_id;
  logic [N-1:0][DATA_W-1:0] unit_rd;
  logic [N-1:0]             unit_ack;
  logic                     wb_ready;
  logic                     wb_valid;
  logic [ID_W-1:0]          wb_id;
  logic [DATA_W-1:0]        wb_data;

  int   checks = 0;
  int   errors = 0;

  int   m_ptr = PTR_RST;
  bit   m_valid = 1'b0;
  pkt_t m_pkt = '0;
  pkt_t sb[$];

  logic [N-1:0] ao, ae;
  bit           vo, ve;
  pkt_t         po, pe;

  writeback_arbiter #(.NUM_UNITS(N), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .unit_done (unit_done),
    .unit_id   (unit_id),
    .unit_rd   (unit_rd),
    .unit_ack  (unit_ack),
    .wb_ready  (wb_ready),
    .wb_valid  (wb_valid),
    .wb_id     (wb_id),
    .wb_data   (wb_data)
  );

  always #5 clk = ~clk;

  function automatic bit done_at(input int idx);
    return ((unit_done >> idx) & N'(1)) != '0;
  endfunction

  function automatic int model_grant();
    int idx;
    if (rst || (m_valid && !wb_ready)) return -1;
`ifdef CVA5_WB_UNIT0_PRIORITY_EN
    if (done_at(0)) return 0;
    for (int k = 0; k < N - 1; k++) begin
      idx = 1 + ((m_ptr - 1 + k) % (N - 1));
      if (done_at(idx)) return idx;
    end
`else
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (done_at(idx)) return idx;
    end
`endif
    return -1;
  endfunction

  function automatic int model_next_ptr(input int g);
`ifdef CVA5_WB_UNIT0_PRIORITY_EN
    if (g == 0) return m_ptr;
    return (g == N - 1) ? 1 : g + 1;
`else
    return (g + 1) % N;
`endif
  endfunction

  // One clock: predict and sample the ack, push the granted result, then pop it after the edge.
  task automatic cyc();
    int   g;
    pkt_t p;
    bit   r, rdy;
    #1;
    g  = model_grant();
    ae = (g >= 0) ? (N'(1) << g) : '0;
    ao = unit_ack;
    if (g >= 0) begin
      p = '0;
      for (int i = 0; i < N; i++) begin
        if (i == g) begin
          p.id   = unit_id[i];
          p.data = unit_rd[i];
        end
      end
      sb.push_back(p);
    end
    r   = rst;
    rdy = wb_ready;
    @(posedge clk);
    #1;
    if (r) begin
      m_valid = 1'b0;
      m_pkt   = '0;
      m_ptr   = PTR_RST;
      sb.delete();
    end else if (g >= 0) begin
      m_pkt   = sb.pop_front();
      m_valid = 1'b1;
      m_ptr   = model_next_ptr(g);
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    ve      = m_valid;
    pe      = m_pkt;
    vo      = wb_valid;
    po.id   = wb_id;
    po.data = wb_data;
  endtask

  task automatic set_unit(input int u, input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d);
    unit_id[u] = id;
    unit_rd[u] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    unit_done = '1;
    wb_ready  = 1'b0;
    for (int i = 0; i < N; i++) set_unit(i, ID_W'(i), DATA_W'(32'h100 + i));
    for (int k = 0; k < 2; k++) begin
      rst = 1'b1;
      cyc();
      checks++;
      if (ao !== '0) begin errors++; $display("FAIL reset_ack got %b want 0000", ao); end
      checks++;
      if (vo !== 1'b0 || po !== '0) begin
        errors++; $display("FAIL reset_out got v=%b %h want v=0 0", vo, po);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_single_source();
    do_reset();
    unit_done = 4'b0100;
    wb_ready  = 1'b1;
    set_unit(2, 3'd5, 32'h0000_00AA);
    cyc();
    checks++;
    if (ao !== 4'b0100 || ao !== ae) begin errors++; $display("FAIL single_ack got %b want 0100", ao); end
    checks++;
    if (vo !== 1'b1 || wb_id !== 3'd5 || wb_data !== 32'hAA) begin
      errors++; $display("FAIL single_pkt got v=%b id=%0d d=%h want v=1 id=5 d=aa", vo, wb_id, wb_data);
    end
    // Pointer now sits at 3: of units 0 and 3, unit 3 wins (unit 0 when it has priority).
    unit_done = 4'b1001;
    set_unit(0, 3'd1, 32'h11);
    set_unit(3, 3'd6, 32'h66);
    cyc();
`ifdef CVA5_WB_UNIT0_PRIORITY_EN
    checks++;
    if (ao !== 4'b0001) begin errors++; $display("FAIL single_ptr got %b want 0001", ao); end
`else
    checks++;
    if (ao !== 4'b1000) begin errors++; $display("FAIL single_ptr got %b want 1000", ao); end
`endif
    checks++;
    if (vo !== ve || po !== pe) begin errors++; $display("FAIL single_next got v=%b %h want v=%b %h", vo, po, ve, pe); end
    unit_done = '0;
    cyc();
    checks++;
    if (vo !== 1'b0 || po !== pe) begin errors++; $display("FAIL single_drain got v=%b %h want v=0 %h", vo, po, pe); end
  endtask

  task automatic test_fairness();
    int order[5];
`ifdef CVA5_WB_UNIT0_PRIORITY_EN
    order = '{0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    do_reset();
    unit_done = 4'b1111;
    wb_ready  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < N; i++) set_unit(i, ID_W'(k + i), DATA_W'(32'hF000 + 16 * k + i));
      cyc();
      checks++;
      if (ao !== (N'(1) << order[k])) begin
        errors++; $display("FAIL fair_order[%0d] got %b want unit %0d", k, ao, order[k]);
      end
      checks++;
      if (vo !== 1'b1 || po !== pe) begin
        errors++; $display("FAIL fair_pkt[%0d] got v=%b %h want v=1 %h", k, vo, po, pe);
      end
    end
  endtask

  task automatic test_backpressure();
    pkt_t held;
    do_reset();
    unit_done = 4'b0001;
    wb_ready  = 1'b1;
    set_unit(0, 3'd3, 32'hCAFE_0003);
    cyc();
    held      = po;
    unit_done = 4'b0010;
    wb_ready  = 1'b0;
    set_unit(1, 3'd4, 32'hBEEF_0004);
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (ao !== '0) begin errors++; $display("FAIL bp_ack[%0d] got %b want 0000", k, ao); end
      checks++;
      if (vo !== 1'b1 || po !== held || po !== pe) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b %h want v=1 %h", k, vo, po, held);
      end
    end
    wb_ready = 1'b1;
    cyc();
    checks++;
    if (ao !== 4'b0010) begin errors++; $display("FAIL bp_release_ack got %b want 0010", ao); end
    checks++;
    if (vo !== 1'b1 || wb_id !== 3'd4 || wb_data !== 32'hBEEF_0004) begin
      errors++; $display("FAIL bp_release_pkt got v=%b id=%0d d=%h want v=1 id=4 d=beef0004", vo, wb_id, wb_data);
    end
  endtask

  task automatic test_wrap_around();
    do_reset();
    wb_ready  = 1'b1;
    unit_done = 4'b0100;
    set_unit(2, 3'd2, 32'h22);
    cyc();
    unit_done = 4'b0011;
    set_unit(0, 3'd0, 32'h1234);
    set_unit(1, 3'd1, 32'h5678);
    cyc();
    checks++;
    if (ao !== 4'b0001) begin errors++; $display("FAIL wrap_ack got %b want 0001", ao); end
    checks++;
    if (vo !== 1'b1 || po !== pe) begin errors++; $display("FAIL wrap_pkt got v=%b %h want v=1 %h", vo, po, pe); end
    unit_done = 4'b0010;
    cyc();
    checks++;
    if (ao !== 4'b0010) begin errors++; $display("FAIL wrap_next got %b want 0010", ao); end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    wb_ready  = 1'b1;
    unit_done = 4'b0001;
    set_unit(0, 3'd7, 32'h7777);
    cyc();
    rst       = 1'b1;
    wb_ready  = 1'b0;
    unit_done = 4'b0010;
    set_unit(1, 3'd6, 32'h6666);
    cyc();
    checks++;
    if (ao !== '0) begin errors++; $display("FAIL midrst_ack got %b want 0000", ao); end
    checks++;
    if (vo !== 1'b0 || po !== '0) begin errors++; $display("FAIL midrst_out got v=%b %h want v=0 0", vo, po); end
    rst      = 1'b0;
    wb_ready = 1'b1;
    cyc();
    checks++;
    if (ao !== 4'b0010) begin errors++; $display("FAIL midrst_regrant got %b want 0010", ao); end
    checks++;
    if (vo !== 1'b1 || wb_id !== 3'd6 || wb_data !== 32'h6666) begin
      errors++; $display("FAIL midrst_pkt got v=%b id=%0d d=%h want v=1 id=6 d=6666", vo, wb_id, wb_data);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst       = ($urandom_range(0, 60) == 0);
      unit_done = N'($urandom);
      wb_ready  = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) set_unit(i, ID_W'($urandom), $urandom);
      cyc();
      checks++;
      if (ao !== ae) begin errors++; $display("FAIL rand_ack[%0d] got %b want %b", k, ao, ae); end
      checks++;
      if (vo !== ve || po !== pe) begin
        errors++; $display("FAIL rand_pkt[%0d] got v=%b %h want v=%b %h", k, vo, po, ve, pe);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    unit_done = '0;
    unit_id   = '0;
    unit_rd   = '0;
    wb_ready  = 1'b0;
    test_reset();
    test_single_source();
    test_fairness();
    test_backpressure();
    test_wrap_around();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
